mac_dot_seq: RTL and testbench
==============================

Name: mac_dot_seq

Overview:
- Sequencer that drives the fixed-latency fp16×fp16+fp32 MAC pipeline to compute dot products.
- Accepts a start command with a vector length and an initial fp32 accumulator.
- Streams fp16 operand pairs in over a valid/ready port and issues one MAC operation per pair, feeding the previous result back as C.
- Presents the final fp32 sum on a valid/ready result port. Sits between the operand source (buffer/DMA) and the MAC pipeline.

Parameters:
- LATENCY, 3, cycles from the mac_issue cycle to the mac_result sample edge; must be ≥1.
- LEN_W, 8, width of the vector length and element counter.

Ports:
- CLK  in  1  clock; all logic on rising edge.
- RESET  in  1  synchronous, active-high reset.
- start  in  1  command strobe; accepted only in IDLE.
- len  in  LEN_W  number of operand pairs; sampled with start.
- init_c  in  32  initial fp32 accumulator; sampled with start.
- in_valid  in  1  operand pair valid.
- in_ready  out  1  operand pair accepted when in_valid&&in_ready.
- in_a  in  16  fp16 operand A.
- in_b  in  16  fp16 operand B.
- mac_issue  out  1  one-cycle pulse; mac_a/mac_b/mac_c valid this cycle.
- mac_a  out  16  operand A to MAC.
- mac_b  out  16  operand B to MAC.
- mac_c  out  32  accumulator input C to MAC.
- mac_result  in  32  MAC fp32 output.
- res_valid  out  1  final result valid.
- res_ready  in  1  result consumer ready.
- res_data  out  32  final dot-product result.
- busy  out  1  high in every state except IDLE.
- remaining  out  LEN_W  pairs not yet accepted.

Behaviour:
- One clock. Reset is synchronous and active-high.
- All outputs are registered except in_ready, which is decoded from state.
- Reset (any state, including mid-WAIT) forces: state=IDLE, all outputs 0, acc=0, latency counter=0. A mac_result arriving after reset is ignored.
- States: IDLE, FETCH, WAIT, DONE.
- IDLE:
  - start=1 loads acc←init_c and remaining←len.
  - len=0 → DONE, with res_data=init_c one cycle later; else → FETCH.
  - start outside IDLE is ignored (no queueing).
- FETCH:
  - in_ready=1.
  - On handshake, the next cycle has mac_issue=1, mac_a=in_a, mac_b=in_b, mac_c=acc; remaining decrements; lat_cnt←LATENCY; → WAIT.
  - With no in_valid, stay in FETCH indefinitely; mac_issue stays 0.
- WAIT:
  - in_ready=0; lat_cnt decrements each cycle.
  - On the edge where lat_cnt reaches 0: acc←mac_result; remaining≠0 → FETCH, else → DONE.
  - Serial dependency: at most one MAC operation in flight.
- DONE:
  - res_valid=1, res_data=acc, held stable until res_ready.
  - On the res_valid&&res_ready edge → IDLE and res_valid←0.
  - start during DONE is ignored.
- mac_a/mac_b/mac_c hold their last value when mac_issue=0.
- Throughput: one pair per LATENCY+2 cycles.
- Total latency for len=N with in_valid held high: 1 (start) + N·(LATENCY+2) cycles to res_valid.
- Width rules:
  - remaining saturates at 0 and never wraps.
  - len=2^LEN_W−1 must complete correctly.

Optional Feature:
- Macro: MAC_DOT_SEQ_ZERO_SKIP_EN.
- Defined:
  - In FETCH, a pair where either operand has bits[14:0]==0 (±0.0) is consumed without issue: remaining decrements, acc unchanged, and the state goes next cycle to FETCH (remaining≠0) or DONE.
  - This covers the MAC datapath's forced hidden bit, which cannot represent zero.
- Undefined: every pair is issued, including zeros.

Test Plan:
- Basic: RESET, start len=1 init_c=0x00000000, pair (0x3C00, 0x4000) → mac_issue once with mac_c=0; bench MAC model returns 0x40000000 after 3 cycles; res_data=0x40000000 and res_valid at cycle 1+5.
- Accumulate: len=3, init_c=0x3F800000, pairs of 1.0×1.0 (0x3C00) → mac_c sequence 0x3F800000, 0x40000000, 0x40400000; res_data=0x40800000.
- Zero length: start len=0 init_c=0x12345678 → no mac_issue; res_valid the next cycle with res_data=0x12345678; res_ready held low for 5 cycles → data stable; state returns to IDLE after res_ready.
- Backpressure/ignore: in_valid toggled 1,0,0,1; start pulsed during WAIT and DONE → no extra issues, remaining counts 2→1→0, start ignored, single result.
- Reset mid-op: RESET during WAIT with lat_cnt=2 → next cycle busy=0, res_valid=0, mac_issue=0; a fresh len=1 command completes normally.
- Zero skip (macro on): len=2, pairs (0x0000, 0x4000) then (0x3C00, 0x3C00), init_c=0 → exactly one mac_issue; pair 1 consumed in 1 cycle. Macro off: two issues.

Source files
------------

// File: rtl/mac_dot_seq.sv
// rtl/mac_dot_seq.sv - dot-product sequencer driving a fixed-latency fp16 x fp16 + fp32 MAC
//
// Purpose:
//   Takes a start command (length, initial fp32 accumulator) and streams fp16
//   operand pairs in. It issues one MAC per pair and feeds each result back as C.
//   At most one MAC is in flight at a time. The final fp32 sum is presented on
//   a valid/ready result port.
//
// Optional feature macro: MAC_DOT_SEQ_ZERO_SKIP_EN
//   When defined, a pair with either operand equal to +/-0.0 is consumed
//   without issuing a MAC. The MAC datapath forces the hidden bit, so it cannot
//   represent zero itself.
//
// Ports:
//   CLK, RESET            clock, synchronous active-high reset
//   start, len, init_c    command strobe, pair count, initial accumulator (IDLE only)
//   in_valid/in_ready     operand pair handshake, in_a/in_b fp16 operands
//   mac_issue             one-cycle pulse; mac_a/mac_b/mac_c valid that cycle
//   mac_result            MAC fp32 output, sampled LATENCY cycles after issue
//   res_valid/res_ready   final result handshake, res_data fp32 sum
//   busy                  high in every state except IDLE
//   remaining             pairs not yet accepted

module mac_dot_seq #(
  parameter int LATENCY = 3,
  parameter int LEN_W   = 8
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic             start,
  input  logic [LEN_W-1:0] len,
  input  logic [31:0]      init_c,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [15:0]      in_a,
  input  logic [15:0]      in_b,
  output logic             mac_issue,
  output logic [15:0]      mac_a,
  output logic [15:0]      mac_b,
  output logic [31:0]      mac_c,
  input  logic [31:0]      mac_result,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [31:0]      res_data,
  output logic             busy,
  output logic [LEN_W-1:0] remaining
);

  localparam int               LAT_W    = (LATENCY < 1) ? 1 : $clog2(LATENCY + 1);
  localparam logic [LAT_W-1:0] LAT_INIT = LAT_W'(LATENCY);

  typedef enum logic [1:0] {
    S_IDLE,
    S_FETCH,
    S_WAIT,
    S_DONE
  } state_e;

  state_e           state_q, state_d;
  logic [31:0]      acc_q, acc_d;
  logic [LEN_W-1:0] rem_q, rem_d;
  logic [LAT_W-1:0] lat_q, lat_d;
  logic             issue_q, issue_d;
  logic [15:0]      mac_a_q, mac_a_d;
  logic [15:0]      mac_b_q, mac_b_d;
  logic [31:0]      mac_c_q, mac_c_d;
  logic             res_valid_q, res_valid_d;
  logic [31:0]      res_data_q, res_data_d;
  logic             busy_q, busy_d;
  logic             handshake;
  logic             skip_pair;

  // The only unregistered output: decoded straight from state.
  assign in_ready  = (state_q == S_FETCH);
  assign handshake = in_valid && in_ready;

`ifdef MAC_DOT_SEQ_ZERO_SKIP_EN
  // Ignore the sign bit: both +0.0 and -0.0 make the product zero.
  assign skip_pair = (in_a[14:0] == 15'd0) || (in_b[14:0] == 15'd0);
`else
  assign skip_pair = 1'b0;
`endif

  always_comb begin
    state_d   = state_q;
    acc_d     = acc_q;
    rem_d     = rem_q;
    lat_d     = lat_q;
    issue_d   = 1'b0;
    mac_a_d   = mac_a_q;
    mac_b_d   = mac_b_q;
    mac_c_d   = mac_c_q;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          acc_d   = init_c;
          rem_d   = len;
          state_d = (len == '0) ? S_DONE : S_FETCH;
        end
      end

      S_FETCH: begin
        if (handshake) begin
          // Saturating decrement; never wraps even if entered with zero.
          rem_d = (rem_q != '0) ? (rem_q - LEN_W'(1)) : '0;
          if (skip_pair) begin
            state_d = (rem_d != '0) ? S_FETCH : S_DONE;
          end else begin
            issue_d = 1'b1;
            mac_a_d = in_a;
            mac_b_d = in_b;
            mac_c_d = acc_q;
            lat_d   = LAT_INIT;
            state_d = S_WAIT;
          end
        end
      end

      S_WAIT: begin
        if (lat_q == '0) begin
          acc_d   = mac_result;
          state_d = (rem_q != '0) ? S_FETCH : S_DONE;
        end else begin
          lat_d = lat_q - LAT_W'(1);
        end
      end

      S_DONE: begin
        if (res_valid_q && res_ready) begin
          state_d = S_IDLE;
        end
      end

      default: state_d = S_IDLE;
    endcase

    // Registered outputs are derived from the next state so they line up with it.
    busy_d      = (state_d != S_IDLE);
    res_valid_d = (state_d == S_DONE);
    // acc does not change while in DONE, so res_data stays stable until accepted.
    res_data_d  = (state_d == S_DONE) ? acc_d : res_data_q;
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q     <= S_IDLE;
      acc_q       <= '0;
      rem_q       <= '0;
      lat_q       <= '0;
      issue_q     <= 1'b0;
      mac_a_q     <= '0;
      mac_b_q     <= '0;
      mac_c_q     <= '0;
      res_valid_q <= 1'b0;
      res_data_q  <= '0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      rem_q       <= rem_d;
      lat_q       <= lat_d;
      issue_q     <= issue_d;
      mac_a_q     <= mac_a_d;
      mac_b_q     <= mac_b_d;
      mac_c_q     <= mac_c_d;
      res_valid_q <= res_valid_d;
      res_data_q  <= res_data_d;
      busy_q      <= busy_d;
    end
  end

  assign mac_issue = issue_q;
  assign mac_a     = mac_a_q;
  assign mac_b     = mac_b_q;
  assign mac_c     = mac_c_q;
  assign res_valid = res_valid_q;
  assign res_data  = res_data_q;
  assign busy      = busy_q;
  assign remaining = rem_q;

endmodule

// File: tb/tb_mac_dot_seq.sv
// tb/tb_mac_dot_seq.sv - directed self-checking bench for mac_dot_seq

module tb_mac_dot_seq;

  logic        CLK = 1'b0;
  logic        RESET;
  logic        start;
  logic [7:0]  len;
  logic [31:0] init_c;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_a;
  logic [15:0] in_b;
  logic        mac_issue;
  logic [15:0] mac_a;
  logic [15:0] mac_b;
  logic [31:0] mac_c;
  logic [31:0] mac_result;
  logic        res_valid;
  logic        res_ready;
  logic [31:0] res_data;
  logic        busy;
  logic [7:0]  remaining;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  int issue_cnt = 0;
  int base_iss;
  int base_log;
  logic [31:0] c_log[$];

  always #5 CLK = ~CLK;

  mac_dot_seq dut (
    .CLK(CLK), .RESET(RESET), .start(start), .len(len), .init_c(init_c),
    .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b),
    .mac_issue(mac_issue), .mac_a(mac_a), .mac_b(mac_b), .mac_c(mac_c),
    .mac_result(mac_result), .res_valid(res_valid), .res_ready(res_ready),
    .res_data(res_data), .busy(busy), .remaining(remaining)
  );

  // MAC model: hand-computed fp results for the directed vectors; anything
  // else is a token accumulator (c + 1) used for the long-vector run.
  function automatic logic [31:0] mac_model(input logic [15:0] a, input logic [15:0] b,
                                            input logic [31:0] c);
    logic [63:0] key;
    key = {a, b, c};
    case (key)
      64'h3C00_4000_0000_0000: return 32'h4000_0000;  // 1*2+0 = 2
      64'h3C00_3C00_0000_0000: return 32'h3F80_0000;  // 1*1+0 = 1
      64'h3C00_3C00_3F80_0000: return 32'h4000_0000;  // 1*1+1 = 2
      64'h3C00_3C00_4000_0000: return 32'h4040_0000;  // 1*1+2 = 3
      64'h3C00_3C00_4040_0000: return 32'h4080_0000;  // 1*1+3 = 4
      64'h0000_4000_0000_0000: return 32'h0000_0000;  // 0*2+0 = 0
      default:                 return c + 32'd1;
    endcase
  endfunction

  // Three-stage pipeline: the result is visible LATENCY cycles after the issue cycle.
  logic [31:0] s0 = '0, s1 = '0, s2 = '0;
  always @(posedge CLK) begin
    if (mac_issue === 1'b1) begin
      s0 <= mac_model(mac_a, mac_b, mac_c);
      issue_cnt <= issue_cnt + 1;
      c_log.push_back(mac_c);
    end
    s1 <= s0;
    s2 <= s1;
  end
  assign mac_result = s2;

  task automatic tick();
    @(posedge CLK);
    #1;
    cyc = cyc + 1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks = checks + 1;
    assert (obs === exp) else begin
      errors = errors + 1;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic start_cmd(input logic [7:0] l, input logic [31:0] c);
    start  = 1'b1;
    len    = l;
    init_c = c;
    cyc    = 0;
    tick();
    start  = 1'b0;
  endtask

  task automatic wait_res(input string tag, input int limit);
    while (res_valid !== 1'b1 && cyc < limit) tick();
    chk({tag, "_timeout"}, {31'd0, res_valid}, 32'd1);
  endtask

  task automatic accept_res(input string tag);
    res_ready = 1'b1;
    tick();
    res_ready = 1'b0;
    chk({tag, "_rv_drop"}, {31'd0, res_valid}, 32'd0);
    chk({tag, "_idle"}, {31'd0, busy}, 32'd0);
  endtask

  initial begin
    RESET = 1'b1; start = 1'b0; len = '0; init_c = '0;
    in_valid = 1'b0; in_a = '0; in_b = '0; res_ready = 1'b0;
    tick();
    tick();
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_rvalid", {31'd0, res_valid}, 32'd0);
    chk("rst_issue", {31'd0, mac_issue}, 32'd0);
    chk("rst_rem", {24'd0, remaining}, 32'd0);
    chk("rst_ready", {31'd0, in_ready}, 32'd0);
    chk("rst_data", res_data, 32'd0);
    RESET = 1'b0;
    tick();

    // Basic: len=1, one pair, result at cycle 1+5.
    base_iss = issue_cnt; base_log = c_log.size();
    in_valid = 1'b1; in_a = 16'h3C00; in_b = 16'h4000;
    start_cmd(8'd1, 32'h0000_0000);
    chk("b_busy", {31'd0, busy}, 32'd1);
    chk("b_ready", {31'd0, in_ready}, 32'd1);
    chk("b_rem1", {24'd0, remaining}, 32'd1);
    tick();
    in_valid = 1'b0;
    chk("b_issue", {31'd0, mac_issue}, 32'd1);
    chk("b_mac_a", {16'd0, mac_a}, 32'h3C00);
    chk("b_mac_b", {16'd0, mac_b}, 32'h4000);
    chk("b_mac_c", mac_c, 32'h0);
    chk("b_rem0", {24'd0, remaining}, 32'd0);
    chk("b_ready_wait", {31'd0, in_ready}, 32'd0);
    tick();
    chk("b_issue_pulse", {31'd0, mac_issue}, 32'd0);
    chk("b_mac_a_hold", {16'd0, mac_a}, 32'h3C00);
    wait_res("b", 40);
    chk("b_cycle", cyc, 6);
    chk("b_data", res_data, 32'h4000_0000);
    chk("b_issues", issue_cnt - base_iss, 1);
    accept_res("b");

    // Accumulate: three 1.0*1.0 pairs from 1.0.
    base_iss = issue_cnt; base_log = c_log.size();
    in_valid = 1'b1; in_a = 16'h3C00; in_b = 16'h3C00;
    start_cmd(8'd3, 32'h3F80_0000);
    wait_res("acc", 60);
    in_valid = 1'b0;
    chk("acc_cycle", cyc, 16);
    chk("acc_data", res_data, 32'h4080_0000);
    chk("acc_issues", issue_cnt - base_iss, 3);
    chk("acc_c0", c_log[base_log], 32'h3F80_0000);
    chk("acc_c1", c_log[base_log + 1], 32'h4000_0000);
    chk("acc_c2", c_log[base_log + 2], 32'h4040_0000);
    accept_res("acc");

    // Zero length: result next cycle, held while res_ready is low.
    base_iss = issue_cnt;
    start_cmd(8'd0, 32'h1234_5678);
    chk("z_rvalid", {31'd0, res_valid}, 32'd1);
    chk("z_data", res_data, 32'h1234_5678);
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("z_hold_valid", {31'd0, res_valid}, 32'd1);
      chk("z_hold_data", res_data, 32'h1234_5678);
    end
    chk("z_issues", issue_cnt - base_iss, 0);
    accept_res("z");

    // Backpressure and ignored starts.
    base_iss = issue_cnt;
    in_valid = 1'b1; in_a = 16'h3C00; in_b = 16'h3C00;
    start_cmd(8'd2, 32'h0);
    chk("bp_rem2", {24'd0, remaining}, 32'd2);
    tick();
    in_valid = 1'b0;
    chk("bp_issue1", {31'd0, mac_issue}, 32'd1);
    chk("bp_rem1", {24'd0, remaining}, 32'd1);
    tick();
    start = 1'b1; len = 8'd7; init_c = 32'hFFFF_FFFF;
    tick();
    start = 1'b0;
    chk("bp_start_wait", {24'd0, remaining}, 32'd1);
    tick();
    tick();
    chk("bp_fetch_ready", {31'd0, in_ready}, 32'd1);
    chk("bp_stall_issue", {31'd0, mac_issue}, 32'd0);
    tick();
    chk("bp_stall2_issue", {31'd0, mac_issue}, 32'd0);
    chk("bp_stall_rem", {24'd0, remaining}, 32'd1);
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    chk("bp_issue2", {31'd0, mac_issue}, 32'd1);
    chk("bp_rem0", {24'd0, remaining}, 32'd0);
    wait_res("bp", 60);
    chk("bp_cycle", cyc, 12);
    start = 1'b1; len = 8'd5;
    tick();
    start = 1'b0;
    chk("bp_done_hold", {31'd0, res_valid}, 32'd1);
    chk("bp_data", res_data, 32'h4000_0000);
    chk("bp_done_rem", {24'd0, remaining}, 32'd0);
    accept_res("bp");
    tick();
    chk("bp_no_queue", {31'd0, busy}, 32'd0);
    chk("bp_issues", issue_cnt - base_iss, 2);

    // Reset during WAIT with lat_cnt=2.
    in_valid = 1'b1; in_a = 16'h3C00; in_b = 16'h4000;
    start_cmd(8'd1, 32'h0);
    tick();
    in_valid = 1'b0;
    tick();
    RESET = 1'b1;
    tick();
    RESET = 1'b0;
    chk("rm_busy", {31'd0, busy}, 32'd0);
    chk("rm_rvalid", {31'd0, res_valid}, 32'd0);
    chk("rm_issue", {31'd0, mac_issue}, 32'd0);
    chk("rm_mac_c", mac_c, 32'd0);
    for (int i = 0; i < 4; i++) tick();
    chk("rm_ignored", {31'd0, busy | res_valid}, 32'd0);
    in_valid = 1'b1; in_a = 16'h3C00; in_b = 16'h3C00;
    start_cmd(8'd1, 32'h3F80_0000);
    wait_res("rm", 40);
    in_valid = 1'b0;
    chk("rm_cycle", cyc, 6);
    chk("rm_data", res_data, 32'h4000_0000);
    accept_res("rm");

    // Zero operand pair.
    base_iss = issue_cnt;
    in_valid = 1'b1; in_a = 16'h0000; in_b = 16'h4000;
    start_cmd(8'd2, 32'h0);
    tick();
    in_a = 16'h3C00; in_b = 16'h3C00;
`ifdef MAC_DOT_SEQ_ZERO_SKIP_EN
    chk("zs_no_issue", {31'd0, mac_issue}, 32'd0);
    chk("zs_rem", {24'd0, remaining}, 32'd1);
    chk("zs_ready", {31'd0, in_ready}, 32'd1);
`else
    chk("zs_issue", {31'd0, mac_issue}, 32'd1);
    chk("zs_rem", {24'd0, remaining}, 32'd1);
    chk("zs_ready", {31'd0, in_ready}, 32'd0);
`endif
    wait_res("zs", 60);
    in_valid = 1'b0;
`ifdef MAC_DOT_SEQ_ZERO_SKIP_EN
    chk("zs_cycle", cyc, 7);
    chk("zs_issues", issue_cnt - base_iss, 1);
`else
    chk("zs_cycle", cyc, 11);
    chk("zs_issues", issue_cnt - base_iss, 2);
`endif
    chk("zs_data", res_data, 32'h3F80_0000);
    accept_res("zs");

    // Maximum length vector.
    base_iss = issue_cnt;
    in_valid = 1'b1; in_a = 16'h0001; in_b = 16'h0001;
    start_cmd(8'hFF, 32'h0);
    chk("max_rem", {24'd0, remaining}, 32'd255);
    wait_res("max", 2000);
    in_valid = 1'b0;
    chk("max_cycle", cyc, 1276);
    chk("max_data", res_data, 32'h0000_00FF);
    chk("max_issues", issue_cnt - base_iss, 255);
    chk("max_rem_sat", {24'd0, remaining}, 32'd0);
    accept_res("max");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
